// File: rtl/useq_pkg.sv
// -----------------------------------------------------------------------------
// useq_pkg
// Shared definitions for the microsequencer:
//   - next-state select encodings carried in the control word (nssel)
//   - FSM state encodings (FETCH / EXEC)
//   - addressing-mode encodings and their fixed dispatch targets
//   - register-mode (REG_MAP) and opcode (OP_MAP) dispatch tables, each
//     entry carrying an illegal marker
//   - default trap microaddress (first unused control-store slot)
// The tables hold 5-bit targets, matching the 32-word control store.
// -----------------------------------------------------------------------------
package useq_pkg;

  localparam int USEQ_AW  = 5;
  localparam int USEQ_OPW = 3;

  // nssel field of the control word
  localparam logic [1:0] NS_DIRECT    = 2'b00;
  localparam logic [1:0] NS_DISP_MODE = 2'b01;
  localparam logic [1:0] NS_DISP_OP   = 2'b10;
  localparam logic [1:0] NS_COND_ZERO = 2'b11;

  // FSM states
  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_EXEC  = 1'b1;

  // IR addressing-mode field
  localparam logic [1:0] MODE_REG  = 2'b00;
  localparam logic [1:0] MODE_ABDM = 2'b01;
  localparam logic [1:0] MODE_ADRM = 2'b10;
  localparam logic [1:0] MODE_BRZZ = 2'b11;

  // Fixed entry points for the non-register addressing modes
  localparam logic [4:0] MODE_ABDM1_ADDR = 5'd1;
  localparam logic [4:0] MODE_ADRM1_ADDR = 5'd5;
  localparam logic [4:0] MODE_BRZZ1_ADDR = 5'd9;

  // First unused control-store slot; illegal dispatches land here
  localparam logic [4:0] TRAP_ADDR_DEFAULT = 5'd24;

  // Dispatch table entry: target microaddress plus an illegal marker
  typedef struct packed {
    logic       illegal;
    logic [4:0] target;
  } map_entry_t;

  localparam map_entry_t MAP_ILLEGAL = '{illegal: 1'b1, target: 5'd0};

  function automatic map_entry_t map_ok(input logic [4:0] t);
    map_entry_t e;
    e.illegal = 1'b0;
    e.target  = t;
    return e;
  endfunction

  // Register-mode dispatch: opcodes 0..4 are defined, everything else traps.
  // The opcode is presented zero-extended to 8 bits so OPW up to 8 works.
  function automatic map_entry_t reg_map(input logic [7:0] opcode);
    map_entry_t e;
    e = MAP_ILLEGAL;
    case (opcode)
      8'd0:    e = map_ok(5'd15);
      8'd1:    e = map_ok(5'd16);
      8'd2:    e = map_ok(5'd17);
      8'd3:    e = map_ok(5'd19);
      8'd4:    e = map_ok(5'd21);
      default: e = MAP_ILLEGAL;
    endcase
    return e;
  endfunction

  // Opcode dispatch: opcodes 0..3 are defined, everything else traps.
  function automatic map_entry_t op_map(input logic [7:0] opcode);
    map_entry_t e;
    e = MAP_ILLEGAL;
    case (opcode)
      8'd0:    e = map_ok(5'd10);
      8'd1:    e = map_ok(5'd11);
      8'd2:    e = map_ok(5'd12);
      8'd3:    e = map_ok(5'd14);
      default: e = MAP_ILLEGAL;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/useq_if.sv
// -----------------------------------------------------------------------------
// useq_if
// Control-store loop between the microsequencer and the control store.
//   address   microaddress presented to the control store
//   cw_valid  control-store output corresponds to address
//   nssel     next-state select field of the returned control word
//   dbin      direct branch address field of the returned control word
// Modports:
//   master  the microsequencer (drives address/cw_valid)
//   slave   the control store  (drives nssel/dbin)
// -----------------------------------------------------------------------------
interface useq_if #(
  parameter int AW = 5
);

  logic [AW-1:0] address;
  logic          cw_valid;
  logic [1:0]    nssel;
  logic [AW-1:0] dbin;

  modport master (
    output address,
    output cw_valid,
    input  nssel,
    input  dbin
  );

  modport slave (
    input  address,
    input  cw_valid,
    output nssel,
    output dbin
  );

endinterface

// File: rtl/useq_dispatch.sv
// -----------------------------------------------------------------------------
// useq_dispatch
// Purely combinational next-microaddress selection.
// Ports:
//   nssel      in  2    next-state select of the current control word
//   dbin       in  AW   direct branch address of the current control word
//   zero       in  1    ALU zero flag
//   ir_opcode  in  OPW  IR opcode field (OPW <= 8)
//   ir_mode    in  2    IR addressing-mode field
//   next_addr  out AW   microaddress to load at the end of EXEC
//   illegal    out 1    dispatch hit an undefined table entry
// -----------------------------------------------------------------------------
module useq_dispatch
  import useq_pkg::*;
#(
  parameter int            AW        = USEQ_AW,
  parameter int            OPW       = USEQ_OPW,
  parameter logic [AW-1:0] TRAP_ADDR = AW'(TRAP_ADDR_DEFAULT)
) (
  input  logic [1:0]     nssel,
  input  logic [AW-1:0]  dbin,
  input  logic           zero,
  input  logic [OPW-1:0] ir_opcode,
  input  logic [1:0]     ir_mode,
  output logic [AW-1:0]  next_addr,
  output logic           illegal
);

  logic [7:0] op8;
  map_entry_t reg_entry;
  map_entry_t op_entry;

  assign op8 = 8'(ir_opcode);

  always_comb begin
    reg_entry = reg_map(op8);
    op_entry  = op_map(op8);
  end

  always_comb begin
    next_addr = dbin;
    illegal   = 1'b0;
    case (nssel)
      NS_DIRECT: begin
        next_addr = dbin;
      end
      NS_DISP_MODE: begin
        case (ir_mode)
          MODE_REG: begin
            next_addr = AW'(reg_entry.target);
            illegal   = reg_entry.illegal;
          end
          MODE_ABDM: next_addr = AW'(MODE_ABDM1_ADDR);
          MODE_ADRM: next_addr = AW'(MODE_ADRM1_ADDR);
          MODE_BRZZ: next_addr = AW'(MODE_BRZZ1_ADDR);
        endcase
      end
      NS_DISP_OP: begin
        next_addr = AW'(op_entry.target);
        illegal   = op_entry.illegal;
      end
      NS_COND_ZERO: begin
        // AW-bit sum: dbin = all-ones with zero set wraps to 0
        next_addr = dbin + AW'(zero);
      end
    endcase
    // Any undefined table entry redirects to the trap handler
    if (illegal) begin
      next_addr = TRAP_ADDR;
    end
  end

endmodule

// File: rtl/microsequencer.sv
// -----------------------------------------------------------------------------
// microsequencer
// Generates the microaddress for the control store and consumes the
// nssel/dbin fields of the control word that comes back. Every
// microinstruction takes two cycles: FETCH (control store latches
// rom[address]) then EXEC (next address computed and registered).
// Ports:
//   clock        in   1    system clock, rising edge
//   reset_n      in   1    asynchronous active-low reset
//   cs           useq_if.master  address/cw_valid out, nssel/dbin in
//   zero         in   1    ALU zero flag, used in EXEC
//   ir_opcode    in   OPW  IR opcode field
//   ir_mode      in   2    IR addressing-mode field
//   hold         in   1    memory wait request; freezes EXEC
//   trap         out  1    one-cycle pulse in the FETCH after an illegal dispatch
//   ustep_count  out  16   completed microinstructions (only with USEQ_TRACE_EN)
// Optional feature macro: USEQ_TRACE_EN (adds the ustep_count port/counter).
// Datapath writes elsewhere must be qualified with cw_valid && !hold so each
// write happens exactly once per microinstruction.
// -----------------------------------------------------------------------------
module microsequencer
  import useq_pkg::*;
#(
  parameter int            AW        = USEQ_AW,
  parameter int            OPW       = USEQ_OPW,
  parameter logic [AW-1:0] TRAP_ADDR = AW'(TRAP_ADDR_DEFAULT)
) (
  input  logic           clock,
  input  logic           reset_n,
  useq_if.master         cs,
  input  logic           zero,
  input  logic [OPW-1:0] ir_opcode,
  input  logic [1:0]     ir_mode,
  input  logic           hold,
  output logic           trap
`ifdef USEQ_TRACE_EN
  ,
  output logic [15:0]    ustep_count
`endif
);

  logic [0:0]    state;
  logic [AW-1:0] address_q;
  logic          cw_valid_q;
  logic [AW-1:0] next_addr;
  logic          illegal;
  logic          advance;

  useq_dispatch #(
    .AW        (AW),
    .OPW       (OPW),
    .TRAP_ADDR (TRAP_ADDR)
  ) u_dispatch (
    .nssel     (cs.nssel),
    .dbin      (cs.dbin),
    .zero      (zero),
    .ir_opcode (ir_opcode),
    .ir_mode   (ir_mode),
    .next_addr (next_addr),
    .illegal   (illegal)
  );

  // A microinstruction completes on the EXEC edge that is not held off
  assign advance = (state == S_EXEC) && !hold;

  // FETCH/EXEC sequencing; hold only matters in EXEC
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_FETCH;
      address_q  <= '0;
      cw_valid_q <= 1'b0;
      trap       <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          state      <= S_EXEC;
          cw_valid_q <= 1'b1;
          trap       <= 1'b0;
        end
        S_EXEC: begin
          if (advance) begin
            state      <= S_FETCH;
            address_q  <= next_addr;
            cw_valid_q <= 1'b0;
            // Pulse lasts exactly the FETCH cycle that follows
            trap       <= illegal;
          end
        end
        default: begin
          state      <= S_FETCH;
          cw_valid_q <= 1'b0;
          trap       <= 1'b0;
        end
      endcase
    end
  end

`ifdef USEQ_TRACE_EN
  // Completed-microinstruction counter; wraps naturally at 16 bits
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ustep_count <= '0;
    end else if (advance) begin
      ustep_count <= ustep_count + 16'd1;
    end
  end
`endif

  assign cs.address  = address_q;
  assign cs.cw_valid = cw_valid_q;

endmodule

// File: tb/tb_microsequencer.sv
// -----------------------------------------------------------------------------
// tb_microsequencer
// Directed and randomized stimulus for microsequencer, checked each cycle
// against a transaction-level reference model (phase flag, expected address,
// trap, and step count when USEQ_TRACE_EN is defined).
// -----------------------------------------------------------------------------
module tb_microsequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       zero;
  logic [2:0] ir_opcode;
  logic [1:0] ir_mode;
  logic       hold;
  logic       trap;
`ifdef USEQ_TRACE_EN
  logic [15:0] ustep_count;
  int          m_count;
  int          cnt_before;
`endif

  useq_if #(.AW(5)) cs ();

  microsequencer #(
    .AW        (5),
    .OPW       (3),
    .TRAP_ADDR (5'd24)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cs        (cs),
    .zero      (zero),
    .ir_opcode (ir_opcode),
    .ir_mode   (ir_mode),
    .hold      (hold),
    .trap      (trap)
`ifdef USEQ_TRACE_EN
    ,
    .ustep_count (ustep_count)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: instruction phase, current address, trap pulse
  int m_addr;
  bit m_valid;
  bit m_trap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Next microaddress straight from the rule tables
  function automatic void ref_next(input logic [1:0] ns, input logic [4:0] db, input logic z,
                                   input logic [2:0] op, input logic [1:0] md,
                                   output int a, output bit ill);
    int reg_tbl [8] = '{15, 16, 17, 19, 21, -1, -1, -1};
    int op_tbl  [8] = '{10, 11, 12, 14, -1, -1, -1, -1};
    int mode_tbl[4] = '{0, 1, 5, 9};
    int t;
    case (ns)
      2'd0:    t = int'(db);
      2'd1:    t = (md == 2'd0) ? reg_tbl[op] : mode_tbl[md];
      2'd2:    t = op_tbl[op];
      default: t = (int'(db) + int'(z)) % 32;
    endcase
    ill = (t < 0);
    a   = ill ? 24 : t;
  endfunction

  task automatic model_reset();
    m_addr  = 0;
    m_valid = 0;
    m_trap  = 0;
`ifdef USEQ_TRACE_EN
    m_count = 0;
`endif
  endtask

  task automatic check_state(input string tag);
    chk({tag, "/address"},  cs.address,  m_addr);
    chk({tag, "/cw_valid"}, cs.cw_valid, m_valid);
    chk({tag, "/trap"},     trap,        m_trap);
`ifdef USEQ_TRACE_EN
    chk({tag, "/ustep"},    ustep_count, m_count & 16'hFFFF);
`endif
  endtask

  // One clock: advance the model with the inputs as they stand, then compare
  task automatic cycle(input string tag);
    int a;
    bit ill;
    if (!m_valid) begin
      m_valid = 1;
      m_trap  = 0;
    end else if (!hold) begin
      ref_next(cs.nssel, cs.dbin, zero, ir_opcode, ir_mode, a, ill);
      m_addr  = a;
      m_trap  = ill;
      m_valid = 0;
`ifdef USEQ_TRACE_EN
      m_count = m_count + 1;
`endif
    end
    @(posedge clock);
    #1;
    check_state(tag);
  endtask

  task automatic set_in(input logic [1:0] ns, input logic [4:0] db, input logic z,
                        input logic [2:0] op, input logic [1:0] md, input logic h);
    cs.nssel  = ns;
    cs.dbin   = db;
    zero      = z;
    ir_opcode = op;
    ir_mode   = md;
    hold      = h;
  endtask

  // One full microinstruction from FETCH, plus explicit expected result
  task automatic instr(input logic [1:0] ns, input logic [4:0] db, input logic z,
                       input logic [2:0] op, input logic [1:0] md,
                       input logic [4:0] exp_a, input logic exp_t, input string tag);
    set_in(ns, db, z, op, md, 1'b0);
    cycle({tag, "_fetch"});
    cycle({tag, "_exec"});
    chk({tag, "_target"}, cs.address, exp_a);
    chk({tag, "_trap"},   trap,       exp_t);
  endtask

  initial begin
    reset_n = 1'b0;
    set_in(2'd0, 5'd0, 1'b0, 3'd0, 2'd0, 1'b0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_state("reset");
    chk("reset_addr_const", cs.address, 0);
    reset_n = 1'b1;

    // Direct branch: cadence 0 -> 1 -> 0, address 0 -> 23 on the 2nd edge
    set_in(2'd0, 5'd23, 1'b0, 3'd0, 2'd0, 1'b0);
    cycle("dir_fetch");
    chk("dir_e1_valid", cs.cw_valid, 1);
    chk("dir_e1_addr",  cs.address,  0);
    cycle("dir_exec");
    chk("dir_e2_valid", cs.cw_valid, 0);
    chk("dir_e2_addr",  cs.address,  23);
    set_in(2'd3, 5'd6, 1'b1, 3'd0, 2'd0, 1'b0);
    cycle("dir_next_fetch");
    chk("dir_next_exec_addr", cs.address, 23);
    cycle("cz1_exec");
    chk("cz1_target", cs.address, 7);

    // Conditional branch on zero
    instr(2'd3, 5'd6,  1'b0, 3'd0, 2'd0, 5'd6, 1'b0, "cz0");
    instr(2'd3, 5'd31, 1'b1, 3'd0, 2'd0, 5'd0, 1'b0, "cz_wrap");

    // Mode dispatch
    instr(2'd1, 5'd0, 1'b0, 3'd4, 2'd0, 5'd21, 1'b0, "mode_reg4");
    instr(2'd1, 5'd0, 1'b0, 3'd0, 2'd1, 5'd1,  1'b0, "mode_abdm");
    instr(2'd1, 5'd0, 1'b0, 3'd0, 2'd2, 5'd5,  1'b0, "mode_adrm");
    instr(2'd1, 5'd0, 1'b0, 3'd0, 2'd3, 5'd9,  1'b0, "mode_brzz");
    instr(2'd1, 5'd0, 1'b0, 3'd6, 2'd0, 5'd24, 1'b1, "mode_ill");
    set_in(2'd2, 5'd0, 1'b0, 3'd3, 2'd0, 1'b0);
    cycle("trap_clear");
    chk("trap_one_cycle", trap, 0);
    cycle("op3_exec");
    chk("op3_target", cs.address, 14);

    // Op dispatch illegal
    instr(2'd2, 5'd0, 1'b0, 3'd5, 2'd0, 5'd24, 1'b1, "op_ill");

    // Hold in EXEC for three cycles
    set_in(2'd0, 5'd13, 1'b0, 3'd0, 2'd0, 1'b0);
    cycle("hold_fetch");
`ifdef USEQ_TRACE_EN
    cnt_before = int'(ustep_count);
`endif
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle("hold_exec");
      chk("hold_addr",  cs.address,  24);
      chk("hold_valid", cs.cw_valid, 1);
    end
    hold = 1'b0;
    cycle("hold_release");
    chk("hold_release_addr", cs.address, 13);
`ifdef USEQ_TRACE_EN
    chk("hold_ustep_plus1", ustep_count, (cnt_before + 1) & 16'hFFFF);
`endif

    // Asynchronous reset in the middle of EXEC with address 17
    instr(2'd1, 5'd0, 1'b0, 3'd2, 2'd0, 5'd17, 1'b0, "to17");
    set_in(2'd0, 5'd2, 1'b0, 3'd0, 2'd0, 1'b0);
    cycle("r17_fetch");
    chk("r17_exec_addr", cs.address, 17);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_addr",  cs.address,  0);
    chk("async_rst_valid", cs.cw_valid, 0);
    chk("async_rst_trap",  trap,        0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    cycle("post_rst_fetch");
    chk("post_rst_exec_addr", cs.address, 0);
    cycle("post_rst_exec");
    chk("post_rst_target", cs.address, 2);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_in(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
